// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side controller shared by the instruction and data caches.
// Two word-request ports are arbitrated round-robin, and each accepted word is
// serialised into four little-endian byte accesses on a byte-wide synchronous RAM.
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 17,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_rw_flag,
  input  logic [31:0]           i_addr,
  output logic [31:0]           i_read_data,
  output logic                  i_busy,
  output logic                  i_done,
  input  logic [1:0]            d_rw_flag,
  input  logic [31:0]           d_addr,
  output logic [31:0]           d_read_data,
  input  logic [31:0]           d_write_data,
  input  logic [3:0]            d_write_mask,
  output logic                  d_busy,
  output logic                  d_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  // Last DRAIN cycle index: reads wait RAM_LATENCY cycles after the final address.
  localparam logic [1:0] DRN_LAST = 2'(RAM_LATENCY - 1);

  state_t                  state_r, state_nxt_s;
  logic [1:0]              k_r, drn_r, xfer_k_s;

  // Request latches (hold a request that is accepted but not yet granted).
  logic                    i_pend_r, d_pend_r;
  logic [ADDR_WIDTH-1:2]   i_addr_r, d_addr_r;
  logic                    d_wr_r;
  logic [31:0]             d_data_r;
  logic [3:0]              d_mask_r;
  logic                    i_busy_r, d_busy_r;

  // Transaction in flight.
  logic                    cur_d_r, cur_wr_r;
  logic [ADDR_WIDTH-1:2]   cur_addr_r;
  logic [31:0]             cur_data_r;
  logic [3:0]              cur_mask_r;
  logic                    last_d_r;

  // Arbitration view: a port is a candidate if it was latched earlier or is being accepted now.
  logic                    i_acc_s, d_acc_s, i_cand_s, d_cand_s;
  logic                    gnt_v_s, gnt_d_s;
  logic [ADDR_WIDTH-1:2]   g_addr_s, src_addr_s;
  logic                    g_wr_s, src_wr_s;
  logic [31:0]             g_data_s, src_data_s;
  logic [3:0]              g_mask_s, src_mask_s;

  logic [ADDR_WIDTH-1:0]   ram_addr_nxt_s;
  logic                    ram_wr_nxt_s;
  logic [7:0]              ram_dout_nxt_s;
  logic                    i_done_nxt_s, d_done_nxt_s;

  logic [31:0]             asm_r;
  logic [31:0]             i_rdata_r, d_rdata_r;
  logic [ADDR_WIDTH-1:0]   ram_addr_r;
  logic                    ram_wr_r, i_done_r, d_done_r;
  logic [7:0]              ram_dout_r;

  // Address bits outside the RAM, the word-offset bits and the icache write bit carry no meaning.
  logic unused_s;
  assign unused_s = ^{i_rw_flag[1], i_addr[31:ADDR_WIDTH], i_addr[1:0],
                      d_addr[31:ADDR_WIDTH], d_addr[1:0]};

  assign i_acc_s  = ~i_busy_r & i_rw_flag[0];
  assign d_acc_s  = ~d_busy_r & (|d_rw_flag);
  assign i_cand_s = i_pend_r | i_acc_s;
  assign d_cand_s = d_pend_r | d_acc_s;

  // Round-robin grant and selection of the granted request (latched copy or live inputs).
  always_comb begin
    gnt_v_s  = 1'b0;
    gnt_d_s  = 1'b0;
    g_addr_s = i_addr_r;
    g_wr_s   = 1'b0;
    g_data_s = 32'h0000_0000;
    g_mask_s = 4'b0000;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      gnt_v_s = i_cand_s | d_cand_s;
      gnt_d_s = d_cand_s & (~i_cand_s | ~last_d_r);
    end else begin
      gnt_v_s = 1'b0;
      gnt_d_s = 1'b0;
    end
    if (gnt_d_s) begin
      g_addr_s = d_pend_r ? d_addr_r : d_addr[ADDR_WIDTH-1:2];
      g_wr_s   = d_pend_r ? d_wr_r   : d_rw_flag[1];
      g_data_s = d_pend_r ? d_data_r : d_write_data;
      g_mask_s = d_pend_r ? d_mask_r : d_write_mask;
    end else begin
      g_addr_s = i_pend_r ? i_addr_r : i_addr[ADDR_WIDTH-1:2];
      g_wr_s   = 1'b0;
      g_data_s = 32'h0000_0000;
      g_mask_s = 4'b0000;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: XFER walks four bytes, reads then drain the RAM pipeline.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        state_nxt_s = gnt_v_s ? XFER : IDLE;
      end
      XFER: begin
        if (k_r == 2'd3) begin
          state_nxt_s = cur_wr_r ? DONE : DRAIN;
        end else begin
          state_nxt_s = XFER;
        end
      end
      DRAIN: begin
        state_nxt_s = (drn_r == DRN_LAST) ? DONE : DRAIN;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered RAM strobes and done pulses.
  always_comb begin
    xfer_k_s       = (state_r == XFER) ? (k_r + 2'd1) : 2'd0;
    src_addr_s     = (state_r == XFER) ? cur_addr_r : g_addr_s;
    src_wr_s       = (state_r == XFER) ? cur_wr_r   : g_wr_s;
    src_data_s     = (state_r == XFER) ? cur_data_r : g_data_s;
    src_mask_s     = (state_r == XFER) ? cur_mask_r : g_mask_s;
    ram_addr_nxt_s = ram_addr_r;
    ram_wr_nxt_s   = 1'b0;
    ram_dout_nxt_s = ram_dout_r;
    if (state_nxt_s == XFER) begin
      ram_addr_nxt_s = {src_addr_s, xfer_k_s};
      ram_wr_nxt_s   = src_wr_s & src_mask_s[xfer_k_s];
      ram_dout_nxt_s = 8'(src_data_s >> {xfer_k_s, 3'b000});
    end else begin
      ram_addr_nxt_s = ram_addr_r;
      ram_wr_nxt_s   = 1'b0;
      ram_dout_nxt_s = ram_dout_r;
    end
    i_done_nxt_s = (state_nxt_s == DONE) && (state_r != DONE) && ~cur_d_r;
    d_done_nxt_s = (state_nxt_s == DONE) && (state_r != DONE) &&  cur_d_r;
  end

  // Request acceptance, pending latches and busy flags per port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_pend_r <= 1'b0;
      d_pend_r <= 1'b0;
      i_addr_r <= '0;
      d_addr_r <= '0;
      d_wr_r   <= 1'b0;
      d_data_r <= 32'h0000_0000;
      d_mask_r <= 4'b0000;
      i_busy_r <= 1'b0;
      d_busy_r <= 1'b0;
    end else begin
      if (i_acc_s) begin
        i_addr_r <= i_addr[ADDR_WIDTH-1:2];
      end
      if (d_acc_s) begin
        d_addr_r <= d_addr[ADDR_WIDTH-1:2];
        d_wr_r   <= d_rw_flag[1];
        d_data_r <= d_write_data;
        d_mask_r <= d_write_mask;
      end
      if (gnt_v_s && !gnt_d_s) begin
        i_pend_r <= 1'b0;
      end else if (i_acc_s) begin
        i_pend_r <= 1'b1;
      end
      if (gnt_v_s && gnt_d_s) begin
        d_pend_r <= 1'b0;
      end else if (d_acc_s) begin
        d_pend_r <= 1'b1;
      end
      if (i_acc_s) begin
        i_busy_r <= 1'b1;
      end else if (i_done_nxt_s) begin
        i_busy_r <= 1'b0;
      end
      if (d_acc_s) begin
        d_busy_r <= 1'b1;
      end else if (d_done_nxt_s) begin
        d_busy_r <= 1'b0;
      end
    end
  end

  // Capture the granted request as the current transaction and remember who won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_d_r    <= 1'b0;
      cur_wr_r   <= 1'b0;
      cur_addr_r <= '0;
      cur_data_r <= 32'h0000_0000;
      cur_mask_r <= 4'b0000;
      last_d_r   <= 1'b0;
    end else if (gnt_v_s) begin
      cur_d_r    <= gnt_d_s;
      cur_wr_r   <= g_wr_s;
      cur_addr_r <= g_addr_s;
      cur_data_r <= g_data_s;
      cur_mask_r <= g_mask_s;
      last_d_r   <= gnt_d_s;
    end
  end

  // Byte/drain counters and registered RAM interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r        <= 2'd0;
      drn_r      <= 2'd0;
      ram_addr_r <= '0;
      ram_wr_r   <= 1'b0;
      ram_dout_r <= 8'h00;
    end else begin
      k_r        <= (state_nxt_s == XFER) ? xfer_k_s : k_r;
      drn_r      <= (state_r == DRAIN) ? (drn_r + 2'd1) : 2'd0;
      ram_addr_r <= ram_addr_nxt_s;
      ram_wr_r   <= ram_wr_nxt_s;
      ram_dout_r <= ram_dout_nxt_s;
    end
  end

  // Read assembly: shift every RAM byte in from the top; the final four shifts are bytes 0..3,
  // with byte 3 arriving on the same edge that enters DONE, so it is taken straight from ram_din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_r     <= 32'h0000_0000;
      i_rdata_r <= 32'h0000_0000;
      d_rdata_r <= 32'h0000_0000;
      i_done_r  <= 1'b0;
      d_done_r  <= 1'b0;
    end else begin
      if ((state_r == XFER) || (state_r == DRAIN)) begin
        asm_r <= {ram_din, asm_r[31:8]};
      end
      if (i_done_nxt_s && !cur_wr_r) begin
        i_rdata_r <= {ram_din, asm_r[31:8]};
      end
      if (d_done_nxt_s && !cur_wr_r) begin
        d_rdata_r <= {ram_din, asm_r[31:8]};
      end
      i_done_r <= i_done_nxt_s;
      d_done_r <= d_done_nxt_s;
    end
  end

  assign i_read_data = i_rdata_r;
  assign d_read_data = d_rdata_r;
  assign i_busy      = i_busy_r;
  assign d_busy      = d_busy_r;
  assign i_done      = i_done_r;
  assign d_done      = d_done_r;
  assign ram_addr    = ram_addr_r;
  assign ram_wr      = ram_wr_r;
  assign ram_dout    = ram_dout_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected completions and RAM
// writes into queues; a negedge monitor pops and compares them as they appear.
module tb_mem_ctrl;

  // 16-bit RAM address so that bit 16 of a request address lies above the RAM.
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    i_rw_flag = 2'b00;
  logic [31:0]   i_addr = 32'h0;
  logic [31:0]   i_read_data;
  logic          i_busy, i_done;
  logic [1:0]    d_rw_flag = 2'b00;
  logic [31:0]   d_addr = 32'h0;
  logic [31:0]   d_read_data;
  logic [31:0]   d_write_data = 32'h0;
  logic [3:0]    d_write_mask = 4'b0000;
  logic          d_busy, d_done;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din = 8'h00;

  mem_ctrl #(.ADDR_WIDTH(AW), .RAM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .i_rw_flag(i_rw_flag), .i_addr(i_addr), .i_read_data(i_read_data),
    .i_busy(i_busy), .i_done(i_done),
    .d_rw_flag(d_rw_flag), .d_addr(d_addr), .d_read_data(d_read_data),
    .d_write_data(d_write_data), .d_write_mask(d_write_mask),
    .d_busy(d_busy), .d_done(d_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte RAM, one cycle read latency.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_dout;
    ram_din <= mem[ram_addr];
  end

  typedef struct { logic [31:0] data; bit rd; int cyc; } exp_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] b; } wr_t;
  exp_t iq[$];
  exp_t dq[$];
  wr_t  wq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input bit port_d, input logic [31:0] data, input bit rd, input int c);
    exp_t e;
    e.data = data; e.rd = rd; e.cyc = c;
    if (port_d) dq.push_back(e); else iq.push_back(e);
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [7:0] b);
    wr_t w;
    w.a = a; w.b = b;
    wq.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_rw_flag = 2'b00;
    d_rw_flag = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || wq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (iq.size() != 0 || dq.size() != 0 || wq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: pending i=%0d d=%0d wr=%0d expected 0", iq.size(), dq.size(), wq.size());
      iq.delete(); dq.delete(); wq.delete();
    end
    repeat (4) tick();
  endtask

  // Monitor: every done pulse and every RAM write must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (!rst) begin
      if (i_done) begin
        if (iq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL i_done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = iq.pop_front();
          chk("i_done_cycle", cyc, e.cyc);
          chk("i_busy_in_done", {31'd0, i_busy}, 32'd0);
          if (e.rd) chk("i_read_data", i_read_data, e.data);
        end
      end
      if (d_done) begin
        if (dq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL d_done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = dq.pop_front();
          chk("d_done_cycle", cyc, e.cyc);
          chk("d_busy_in_done", {31'd0, d_busy}, 32'd0);
          if (e.rd) chk("d_read_data", d_read_data, e.data);
        end
      end
      if (ram_wr) begin
        if (wq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL ram_wr_unexpected: addr %h data %h", ram_addr, ram_dout);
        end else begin
          w = wq.pop_front();
          chk("ram_wr_addr", {16'd0, ram_addr}, {16'd0, w.a});
          chk("ram_wr_data", {24'd0, ram_dout}, {24'd0, w.b});
        end
      end
    end
  end

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    mem[16'h0200] = 8'h01; mem[16'h0201] = 8'h02; mem[16'h0202] = 8'h03; mem[16'h0203] = 8'h04;

    do_reset();
    chk("rst_i_busy", {31'd0, i_busy}, 32'd0);
    chk("rst_d_busy", {31'd0, d_busy}, 32'd0);
    chk("rst_i_done", {31'd0, i_done}, 32'd0);
    chk("rst_d_done", {31'd0, d_done}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_i_read_data", i_read_data, 32'd0);
    chk("rst_d_read_data", d_read_data, 32'd0);

    // 1: d read of 0x100
    n = cyc;
    d_rw_flag = 2'b01; d_addr = 32'h0000_0100;
    push_x(1'b1, 32'h4433_2211, 1'b1, n + 6);
    tick();
    d_rw_flag = 2'b00;
    wait_idle(30);

    // 2: masked write then read-back keeping untouched bytes
    n = cyc;
    d_rw_flag = 2'b10; d_addr = 32'h0000_0200;
    d_write_data = 32'hAABB_CCDD; d_write_mask = 4'b0101;
    push_w(16'h0200, 8'hDD);
    push_w(16'h0202, 8'hBB);
    push_x(1'b1, 32'h0, 1'b0, n + 5);
    tick();
    d_rw_flag = 2'b00;
    wait_idle(30);
    n = cyc;
    d_rw_flag = 2'b01; d_addr = 32'h0000_0200;
    push_x(1'b1, 32'h04BB_02DD, 1'b1, n + 6);
    tick();
    d_rw_flag = 2'b00;
    wait_idle(30);

    // 3: simultaneous requests after reset: d first, i back to back
    do_reset();
    n = cyc;
    i_rw_flag = 2'b01; i_addr = 32'h0000_0100;
    d_rw_flag = 2'b01; d_addr = 32'h0000_0200;
    push_x(1'b1, 32'h04BB_02DD, 1'b1, n + 6);
    push_x(1'b0, 32'h4433_2211, 1'b1, n + 12);
    tick();
    i_rw_flag = 2'b00; d_rw_flag = 2'b00;
    while (cyc < n + 6) tick();
    chk("i_busy_while_waiting", {31'd0, i_busy}, 32'd1);
    wait_idle(30);

    // 4: i re-requests in each done cycle, d requests continuously: grants alternate
    do_reset();
    n = cyc;
    i_rw_flag = 2'b01; i_addr = 32'h0000_0100;
    d_rw_flag = 2'b01; d_addr = 32'h0000_0200;
    for (int j = 0; j < 4; j++) push_x(1'b1, 32'h04BB_02DD, 1'b1, n + 6 + 12 * j);
    for (int j = 0; j < 3; j++) push_x(1'b0, 32'h4433_2211, 1'b1, n + 12 + 12 * j);
    while (cyc < n + 25) tick();
    i_rw_flag = 2'b00;
    while (cyc < n + 31) tick();
    d_rw_flag = 2'b00;
    wait_idle(40);

    // 5: reset in cycle 3 of a write aborts it without a done pulse
    n = cyc;
    d_rw_flag = 2'b10; d_addr = 32'h0000_0300;
    d_write_data = 32'h1234_5678; d_write_mask = 4'b1111;
    push_w(16'h0300, 8'h78);
    push_w(16'h0301, 8'h56);
    tick();
    d_rw_flag = 2'b00;
    while (cyc < n + 3) tick();
    rst = 1'b1;
    #1;
    chk("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("abort_d_busy", {31'd0, d_busy}, 32'd0);
    chk("abort_d_done", {31'd0, d_done}, 32'd0);
    chk("abort_ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("abort_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("abort_i_read_data", i_read_data, 32'd0);
    chk("abort_d_read_data", d_read_data, 32'd0);
    chk("abort_writes_seen", wq.size(), 32'd0);
    wq.delete();
    tick(); tick();
    rst = 1'b0;
    repeat (8) tick();
    n = cyc;
    d_rw_flag = 2'b01; d_addr = 32'h0000_0100;
    push_x(1'b1, 32'h4433_2211, 1'b1, n + 6);
    tick();
    d_rw_flag = 2'b00;
    wait_idle(30);

    // 6: icache write-only flag ignored, upper and low address bits dropped
    n = cyc;
    i_rw_flag = 2'b10; i_addr = 32'h0000_0300;
    d_rw_flag = 2'b01; d_addr = 32'h0001_0103;
    push_x(1'b1, 32'h4433_2211, 1'b1, n + 6);
    tick();
    d_rw_flag = 2'b00;
    chk("i_busy_ignored", {31'd0, i_busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("ram_addr_trunc", {16'd0, ram_addr}, 32'h0000_0100 + 32'(k));
      tick();
    end
    wait_idle(30);
    i_rw_flag = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory-side controller below the instruction and data caches. It accepts 32-bit word requests on two cache-facing ports, arbitrates between them, and serialises each request into four byte accesses on a byte-wide synchronous RAM. It returns the assembled read word or write completion through a busy/done handshake. The port signals are the same as the caches' mem_* interface.

Parameters:
ADDR_WIDTH, 17, byte-address width of the RAM; upper request address bits are ignored.
RAM_LATENCY, 1, clock cycles from ram_addr presented to ram_din valid; supported values are 1 and 2.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-high reset.
i_rw_flag  input  2  icache request; bit[0] = read; bit[1] is ignored (the port is read-only).
i_addr  input  32  icache word address; bits [1:0] are ignored.
i_read_data  output  32  icache read word.
i_busy  output  1  icache request accepted and not yet done.
i_done  output  1  one-cycle completion pulse for icache.
d_rw_flag  input  2  dcache request; [0] = read, [1] = write; 2'b11 is treated as a write.
d_addr  input  32  dcache word address; bits [1:0] are ignored.
d_read_data  output  32  dcache read word.
d_write_data  input  32  dcache write word.
d_write_mask  input  4  byte enables; bit k enables byte k.
d_busy  output  1  dcache request accepted and not yet done.
d_done  output  1  one-cycle completion pulse for dcache.
ram_addr  output  ADDR_WIDTH  RAM byte address.
ram_wr  output  1  RAM write enable.
ram_dout  output  8  RAM write byte.
ram_din  input  8  RAM read byte.

Behaviour:
- Reset values: all busy, done, read_data, ram_addr, ram_dout and ram_wr outputs are 0. State is IDLE, both pending latches are clear, and last_grant = icache. Reset takes effect asynchronously and can abort a transaction mid-flight; ram_wr drops immediately and no done pulse is produced.
- Acceptance: a port whose busy is low and whose rw_flag is non-zero has its request latched at the clock edge (accept cycle = cycle 0).
  - The latch holds addr, kind, and for dcache the data and mask.
  - The port's busy goes high from cycle 1.
  - The requester may drop or change its inputs after cycle 0.
- Arbitration: takes place in IDLE.
  - If exactly one port is pending, that port is granted.
  - If both are pending, the port not in last_grant is granted (round-robin); last_grant updates on each grant.
  - A request accepted while the other port is being served waits, with busy high.
- State machine: IDLE -> XFER (byte counter k = 0..3) -> for reads only, DRAIN (RAM_LATENCY cycles) -> DONE -> IDLE.
  - DONE lasts one cycle and acts as an IDLE cycle for arbitration, so transactions can run back to back.
- Byte order is little-endian; byte k is data[8k+7:8k].
- ram_addr = {addr[ADDR_WIDTH-1:2], k[1:0]} during XFER and holds its last value otherwise.
- Read timing (RAM_LATENCY=1, counting from the grant cycle G):
  - Cycles G+1..G+4 present k = 0..3.
  - Byte k is captured from ram_din at the end of cycle G+2+k.
  - done is high and busy low in cycle G+6.
  - read_data is valid in the done cycle and held until that port's next done.
  - Each extra cycle of RAM_LATENCY adds one cycle to the read.
- Write timing:
  - Cycles G+1..G+4 present k = 0..3 with ram_dout = byte k.
  - ram_wr = mask[k] in each of those cycles and is 0 in all other cycles.
  - done is high in cycle G+5.
  - A mask of 4'b0000 still takes the full 4 cycles, with no RAM writes.
- Done cycle:
  - done is high for exactly one cycle and busy is low in that cycle.
  - A new request on the same port in its done cycle is accepted at that edge.
  - Latency from accept to done is 6 cycles for a read and 5 for a write when the other port is idle, because accept and grant coincide (G = 0).
- rw_flag = 2'b00 generates no RAM activity.

Test Plan:
1. RAM holds bytes 0x11,0x22,0x33,0x44 at 0x100..0x103; d read 0x100 -> d_done in cycle 6; d_read_data = 0x44332211; ram_wr never asserted.
2. d write 0x200, data 0xAABBCCDD, mask 4'b0101 -> ram_wr only for addresses 0x200 (0xDD) and 0x202 (0xBB); d_done in cycle 5; a read-back of 0x200 returns 0x??BB??DD with the old bytes kept.
3. i and d both request in the same cycle after reset -> d is served first; i_busy stays high; i is served directly after d_done with no idle gap; i_done in cycle 12.
4. i issues 3 consecutive reads, re-requesting in each done cycle, while d re-requests continuously -> grants alternate d,i,d,i; neither port starves.
5. rst asserted in cycle 3 of a write -> ram_wr is 0 immediately; no done pulse; all outputs are 0; a later read completes normally.
6. i_rw_flag = 2'b10 and d_addr = 0x0001_0103 -> the i request is ignored; the d access uses byte addresses 0x0100..0x0103 (upper bits dropped, addr[1:0] forced to 0).
